// File: rtl/calc_pkg.sv
// Shared keycodes, opcode and state encodings for the calculator entry path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } opcode_e;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        REQUEST = 3'd2,
        RESULT  = 3'd3,
        ERROR   = 3'd4
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
    endfunction

    function automatic opcode_e key_to_op(input logic [3:0] k);
        case (k)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            default: return OP_MUL;
        endcase
    endfunction

endpackage

// File: rtl/keypad_entry_controller_if.sv
// Request/ack bus between the entry controller and the arithmetic unit.
// Latency: n/a (wires only).
// Backpressure: calc_req held until calc_ack; the unit stalls the controller by withholding ack.
interface keypad_entry_controller_if #(
    parameter int WIDTH = 16
);
    logic             calc_req;
    logic             calc_ack;
    logic [WIDTH-1:0] calc_result;
    logic             calc_error;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [1:0]       opcode;

    modport master (
        output calc_req, operand_a, operand_b, opcode,
        input  calc_ack, calc_result, calc_error
    );

    modport slave (
        input  calc_req, operand_a, operand_b, opcode,
        output calc_ack, calc_result, calc_error
    );
endinterface

// File: rtl/digit_accumulator.sv
// Decimal operand register: value*10+d per digit, capped at DIGITS digits.
// Latency: 1 cycle from control to value/count.
// Backpressure: none; digits beyond the cap are silently dropped.
module digit_accumulator #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16,
    localparam int CW    = $clog2(DIGITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic [CW-1:0]    load_count_i,
    input  logic             digit_vld_i,
    input  logic [3:0]       digit_i,
    output logic [WIDTH-1:0] value_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] value_q, value_d;
    logic [CW-1:0]    count_q, count_d;

    // Next value: clear beats load beats digit; a full operand ignores digits.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clear_i) begin
            value_d = '0;
            count_d = '0;
        end else if (load_i) begin
            value_d = load_value_i;
            count_d = load_count_i;
        end else if (digit_vld_i && (count_q < CW'(DIGITS))) begin
            value_d = value_q * WIDTH'(10) + WIDTH'(digit_i);
            count_d = count_q + CW'(1);
        end
    end

    // Operand state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value_o = value_q;
    assign count_o = count_q;
endmodule

// File: rtl/keypad_entry_controller.sv
// Assembles two decimal operands and an operator from key events, runs one req/ack to the ALU.
// Latency: key effects visible the cycle after the strobe's rising edge; calc_req drops the cycle after ack/timeout.
// Backpressure: calc_req held until calc_ack or ACK_TIMEOUT cycles; all keys except nothing are ignored while requesting.
module keypad_entry_controller
    import calc_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 16,
    parameter int ACK_TIMEOUT = 1000,
    localparam int CW         = $clog2(DIGITS + 1),
    localparam int TW         = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          keypressed,
    input  logic [3:0]                    keycode,
    keypad_entry_controller_if.master     calc,
    output logic [WIDTH-1:0]              display_value,
    output logic                          error,
    output logic [2:0]                    state
);
    state_e           state_q;
    opcode_e          opcode_q;
    logic             calc_req_q;
    logic [WIDTH-1:0] result_q;
    logic [TW-1:0]    timer_q;
    logic             kp_q;

    logic             key_evt, is_dig, is_op, is_clr, is_eq;
    logic [WIDTH-1:0] a_value, b_value;
    logic [CW-1:0]    a_count, b_count;

    logic             a_clear, a_load, a_dig, b_clear, b_dig;
    logic [WIDTH-1:0] a_load_value;
    logic [CW-1:0]    a_load_count;

    // One event per rising edge of the strobe, however long it is held.
    assign key_evt = keypressed && !kp_q;
    assign is_dig  = key_evt && is_digit(keycode);
    assign is_op   = key_evt && is_operator(keycode);
    assign is_clr  = key_evt && (keycode == KEY_CLR);
    assign is_eq   = key_evt && (keycode == KEY_EQ);

    // Steer key events into the two operand accumulators based on entry state.
    always_comb begin
        a_clear      = 1'b0;
        a_load       = 1'b0;
        a_dig        = 1'b0;
        a_load_value = '0;
        a_load_count = '0;
        b_clear      = 1'b0;
        b_dig        = 1'b0;
        if (is_clr && (state_q != REQUEST)) begin
            a_clear = 1'b1;
            b_clear = 1'b1;
        end else begin
            case (state_q)
                ENTER_A: a_dig = is_dig;
                ENTER_B: b_dig = is_dig;
                RESULT: begin
                    if (is_dig) begin
                        // New calculation: the digit becomes the whole of operand A.
                        a_load       = 1'b1;
                        a_load_value = WIDTH'(keycode);
                        a_load_count = CW'(1);
                        b_clear      = 1'b1;
                    end else if (is_op) begin
                        // Chaining: the result becomes a full operand A so no digits append to it.
                        a_load       = 1'b1;
                        a_load_value = result_q;
                        a_load_count = CW'(DIGITS);
                        b_clear      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    digit_accumulator #(.DIGITS(DIGITS), .WIDTH(WIDTH)) u_acc_a (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (a_clear),
        .load_i       (a_load),
        .load_value_i (a_load_value),
        .load_count_i (a_load_count),
        .digit_vld_i  (a_dig),
        .digit_i      (keycode),
        .value_o      (a_value),
        .count_o      (a_count)
    );

    digit_accumulator #(.DIGITS(DIGITS), .WIDTH(WIDTH)) u_acc_b (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (b_clear),
        .load_i       (1'b0),
        .load_value_i ('0),
        .load_count_i ('0),
        .digit_vld_i  (b_dig),
        .digit_i      (keycode),
        .value_o      (b_value),
        .count_o      (b_count)
    );

    // Entry/request sequencer with registered request, opcode and latched result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ENTER_A;
            opcode_q   <= OP_ADD;
            calc_req_q <= 1'b0;
            result_q   <= '0;
            timer_q    <= '0;
            kp_q       <= 1'b0;
        end else begin
            kp_q <= keypressed;
            if (is_clr && (state_q != REQUEST)) begin
                state_q    <= ENTER_A;
                opcode_q   <= OP_ADD;
                calc_req_q <= 1'b0;
                result_q   <= '0;
                timer_q    <= '0;
            end else begin
                case (state_q)
                    ENTER_A: begin
                        if (is_op && (a_count != '0)) begin
                            opcode_q <= key_to_op(keycode);
                            state_q  <= ENTER_B;
                        end
                    end
                    ENTER_B: begin
                        if (is_op && (b_count == '0)) begin
                            opcode_q <= key_to_op(keycode);
                        end else if (is_eq && (b_count != '0)) begin
                            state_q    <= REQUEST;
                            calc_req_q <= 1'b1;
                            timer_q    <= '0;
                        end
                    end
                    REQUEST: begin
                        // Ack is checked first so it wins over a simultaneous timeout.
                        if (calc.calc_ack) begin
                            result_q   <= calc.calc_result;
                            calc_req_q <= 1'b0;
                            state_q    <= calc.calc_error ? ERROR : RESULT;
                        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                            calc_req_q <= 1'b0;
                            state_q    <= ERROR;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    RESULT: begin
                        if (is_dig) begin
                            state_q <= ENTER_A;
                        end else if (is_op) begin
                            opcode_q <= key_to_op(keycode);
                            state_q  <= ENTER_B;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Display mux from registered state only.
    always_comb begin
        display_value = '0;
        case (state_q)
            ENTER_A: display_value = a_value;
            ENTER_B: display_value = (b_count != '0) ? b_value : a_value;
            REQUEST: display_value = b_value;
            RESULT:  display_value = result_q;
            default: display_value = '0;
        endcase
    end

    assign calc.calc_req  = calc_req_q;
    assign calc.operand_a = a_value;
    assign calc.operand_b = b_value;
    assign calc.opcode    = opcode_q;
    assign error          = (state_q == ERROR);
    assign state          = state_q;
endmodule

// File: tb/tb_keypad_entry_controller.sv
// Random and directed key/ack stimulus against a behavioural calculator-entry model.
// Latency: model predicts outputs one edge after each sampled input.
// Backpressure: bench plays the arithmetic unit with random ack delays, including none.
module tb_keypad_entry_controller;
    localparam int DIGITS = 4;
    localparam int WIDTH  = 16;
    localparam int TMO    = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             kp = 1'b0;
    logic [3:0]       code = 4'h0;
    logic [WIDTH-1:0] disp;
    logic             err_o;
    logic [2:0]       st_o;

    keypad_entry_controller_if #(.WIDTH(WIDTH)) bus ();

    keypad_entry_controller #(.DIGITS(DIGITS), .WIDTH(WIDTH), .ACK_TIMEOUT(TMO)) dut (
        .clock         (clk),
        .reset         (rst),
        .keypressed    (kp),
        .keycode       (code),
        .calc          (bus.master),
        .display_value (disp),
        .error         (err_o),
        .state         (st_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 entering A, 1 entering B, 2 waiting on ALU, 3 showing result, 4 error.
    int m_mode, m_a, m_ca, m_b, m_cb, m_op, m_res, m_wait;
    bit m_prev;
    bit started = 0;

    always @(posedge clk) begin : model
        bit ev;
        int k;
        if (rst) begin
            m_mode = 0; m_a = 0; m_ca = 0; m_b = 0; m_cb = 0;
            m_op = 0; m_res = 0; m_wait = 0; m_prev = 0;
            started = 1;
        end else if (started) begin
            ev = kp && !m_prev;
            m_prev = kp;
            k = int'(code);
            if (m_mode == 2) begin
                m_wait++;
                if (bus.calc_ack) begin
                    m_res = int'(bus.calc_result);
                    m_mode = bus.calc_error ? 4 : 3;
                end else if (m_wait >= TMO) begin
                    m_mode = 4;
                end
            end else if (ev) begin
                if (k == 13) begin
                    m_mode = 0; m_a = 0; m_ca = 0; m_b = 0; m_cb = 0; m_op = 0; m_res = 0;
                end else if (m_mode == 0) begin
                    if (k <= 9 && m_ca < DIGITS) begin m_a = m_a * 10 + k; m_ca++; end
                    else if (k >= 10 && k <= 12 && m_ca > 0) begin m_op = k - 10; m_mode = 1; end
                end else if (m_mode == 1) begin
                    if (k <= 9 && m_cb < DIGITS) begin m_b = m_b * 10 + k; m_cb++; end
                    else if (k >= 10 && k <= 12 && m_cb == 0) m_op = k - 10;
                    else if (k == 14 && m_cb > 0) begin m_mode = 2; m_wait = 0; end
                end else if (m_mode == 3) begin
                    if (k <= 9) begin
                        m_a = k; m_ca = 1; m_b = 0; m_cb = 0; m_mode = 0;
                    end else if (k >= 10 && k <= 12) begin
                        m_a = m_res; m_ca = DIGITS; m_b = 0; m_cb = 0; m_op = k - 10; m_mode = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        int exp_disp;
        if (started) begin
            chk("calc_req", int'(bus.calc_req), int'(m_mode == 2));
            chk("operand_a", int'(bus.operand_a), m_a);
            chk("operand_b", int'(bus.operand_b), m_b);
            chk("opcode", int'(bus.opcode), m_op);
            chk("error", int'(err_o), int'(m_mode == 4));
            chk("state", int'(st_o), m_mode);
            if (m_mode != 2) begin
                case (m_mode)
                    0: exp_disp = m_a;
                    1: exp_disp = (m_cb > 0) ? m_b : m_a;
                    3: exp_disp = m_res;
                    default: exp_disp = 0;
                endcase
                chk("display_value", int'(disp), exp_disp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input int hold = 1, input int gap = 1);
        kp = 1'b1;
        code = 4'(k);
        repeat (hold) tick();
        kp = 1'b0;
        code = 4'($urandom_range(0, 15));
        repeat (gap) tick();
    endtask

    task automatic press_seq(input int ks[]);
        foreach (ks[i]) press(ks[i]);
    endtask

    task automatic ack_pulse(input int r, input bit e);
        bus.calc_ack = 1'b1;
        bus.calc_result = 16'(r);
        bus.calc_error = e;
        tick();
        bus.calc_ack = 1'b0;
        bus.calc_error = 1'b0;
        bus.calc_result = 16'($urandom_range(0, 65535));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.calc_ack = 1'b0;
        bus.calc_result = '0;
        bus.calc_error = 1'b0;
        do_reset();
        chk("reset state", int'(st_o), 0);
        chk("reset calc_req", int'(bus.calc_req), 0);
        chk("reset display", int'(disp), 0);

        // 12 + 3, ack 15
        press_seq('{1, 2, 10, 3, 14});
        chk("T1 calc_req", int'(bus.calc_req), 1);
        chk("T1 operand_a", int'(bus.operand_a), 12);
        chk("T1 operand_b", int'(bus.operand_b), 3);
        chk("T1 opcode", int'(bus.opcode), 0);
        ack_pulse(15, 1'b0);
        chk("T1 req dropped", int'(bus.calc_req), 0);
        chk("T1 display", int'(disp), 15);
        chk("T1 state", int'(st_o), 3);

        // Chain from result 15: *2, then ALU error
        press_seq('{12, 2, 14});
        chk("T5 operand_a", int'(bus.operand_a), 15);
        chk("T5 opcode", int'(bus.opcode), 2);
        chk("T5 operand_b", int'(bus.operand_b), 2);
        chk("T5 calc_req", int'(bus.calc_req), 1);
        ack_pulse(30, 1'b1);
        chk("T5 state", int'(st_o), 4);
        chk("T5 display", int'(disp), 0);

        // Digit cap and clear
        do_reset();
        press_seq('{13, 1, 2, 3, 4, 5});
        chk("T2 cap", int'(bus.operand_a), 1234);
        press(13);
        chk("T2 clear a", int'(bus.operand_a), 0);
        chk("T2 clear disp", int'(disp), 0);

        // Leading operator ignored, operator replaced before B digits
        press_seq('{10, 7, 10, 11, 2, 14});
        chk("T3 opcode", int'(bus.opcode), 1);
        chk("T3 operand_a", int'(bus.operand_a), 7);
        chk("T3 operand_b", int'(bus.operand_b), 2);
        do_reset();
        press(9, 50);
        chk("T3 held key", int'(bus.operand_a), 9);
        press(9);
        chk("T3 second press", int'(bus.operand_a), 99);

        // Timeout
        do_reset();
        press_seq('{1, 10, 2, 14});
        repeat (TMO + 5) tick();
        chk("T4 calc_req", int'(bus.calc_req), 0);
        chk("T4 error", int'(err_o), 1);
        chk("T4 display", int'(disp), 0);
        press(5);
        chk("T4 key ignored", int'(st_o), 4);
        press(13);
        chk("T4 clear exit", int'(st_o), 0);

        // Ack in the very cycle the timeout expires
        press_seq('{3, 10, 4});
        press(14);
        repeat (TMO - 2) tick();
        chk("T7 still waiting", int'(bus.calc_req), 1);
        ack_pulse(7, 1'b0);
        chk("T7 ack wins", int'(st_o), 3);
        chk("T7 display", int'(disp), 7);

        // Reset during request, late ack ignored
        press_seq('{13, 8, 10, 1, 14});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("T6 req cleared", int'(bus.calc_req), 0);
        chk("T6 state", int'(st_o), 0);
        ack_pulse(99, 1'b0);
        chk("T6 late ack", int'(st_o), 0);
        chk("T6 late ack disp", int'(disp), 0);

        // Random key/ack traffic
        for (int n = 0; n < 2500; n++) begin
            int r, k, dly;
            r = $urandom_range(0, 99);
            if (r < 55)      k = $urandom_range(0, 9);
            else if (r < 75) k = $urandom_range(10, 12);
            else if (r < 88) k = 14;
            else if (r < 93) k = 13;
            else             k = 15;
            press(k, $urandom_range(1, 3), $urandom_range(1, 2));
            if ($urandom_range(0, 99) < 3) ack_pulse($urandom_range(0, 65535), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 199) == 0) do_reset();
            if (bus.calc_req) begin
                r = $urandom_range(0, 99);
                if (r < 96)      dly = $urandom_range(0, 20);
                else if (r < 98) dly = TMO - 3 + $urandom_range(0, 1);
                else             dly = TMO + 10;
                for (int c = 0; c < dly; c++) begin
                    kp = 1'($urandom_range(0, 1));
                    code = 4'($urandom_range(0, 15));
                    tick();
                end
                kp = 1'b0;
                if (dly < TMO) ack_pulse($urandom_range(0, 65535), ($urandom_range(0, 7) == 0));
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_entry_controller.md
Name: keypad_entry_controller

Overview:
- Sits between keypadscanner and the arithmetic unit of the calculator.
- Consumes the scanner's keycode and keypressed strobe and assembles two decimal operands and an operator.
- Sequences a req/ack transaction to the arithmetic unit, then presents the result or error for display.
- Sole owner of calculator entry state; display logic reads only its outputs.

Parameters:
- DIGITS, 4, maximum decimal digits per operand; further digit keys are ignored.
- WIDTH, 16, binary width of operands, result and display value; must hold 10^DIGITS-1.
- ACK_TIMEOUT, 1000, clock cycles to wait for calc_ack before flagging an error.

Ports:
- clock  in  1  system clock, same domain as keypadscanner.
- reset  in  1  synchronous, active-high; clears all state.
- keypressed  in  1  key strobe from scanner; edge-detected internally.
- keycode  in  4  key value, valid while keypressed is high.
- calc_req  out  1  operation request to the arithmetic unit.
- calc_ack  in  1  arithmetic unit has taken the request and result is valid.
- calc_result  in  WIDTH  result, sampled when calc_ack=1.
- calc_error  in  1  overflow/invalid op, sampled when calc_ack=1.
- operand_a  out  WIDTH  first operand, binary.
- operand_b  out  WIDTH  second operand, binary.
- opcode  out  2  00 add, 01 sub, 10 mul.
- display_value  out  WIDTH  value to show.
- error  out  1  high in ERROR state.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset: state=ENTER_A. operand_a=0, operand_b=0, opcode=00, display_value=0, calc_req=0, error=0. Digit counts and timeout counter=0. Edge-detect register=0.
- Key event: keypressed=1 at a clock edge where the previous sample was 0. A strobe held high for any length gives exactly one event. All effects of the event are visible the cycle after that edge.
- Key map:
  - 0-9: digit.
  - A: add. B: sub. C: mul.
  - D: clear.
  - E: equals.
  - F: ignored in all states.
- Digit accumulate: value <= value*10 + d and count++, only if count < DIGITS; otherwise ignored. A leading 0 counts as a digit.
- ENTER_A:
  - Digit: accumulates into operand_a.
  - Operator: if count_a > 0, latch opcode and go to ENTER_B; else ignored.
  - E: ignored.
- ENTER_B:
  - Digit: accumulates into operand_b.
  - Operator: if count_b = 0, replaces opcode; else ignored.
  - E: if count_b > 0, go to REQUEST; else ignored.
- D (clear), in every state except REQUEST: reset-equivalent clear, go to ENTER_A.
- REQUEST:
  - calc_req=1 from the first cycle in state. Operands and opcode are frozen; all keys are ignored.
  - calc_ack=1: latch calc_result into display_value, drop calc_req the next cycle. Go to ERROR if calc_error=1, else RESULT.
  - Timeout: counter increments each cycle in REQUEST. On reaching ACK_TIMEOUT with no ack, drop calc_req and go to ERROR.
  - Ack arriving in the same cycle as timeout expiry: ack wins.
- RESULT:
  - Digit: clear operands and start a new operand_a holding that digit (count_a=1); go to ENTER_A.
  - Operator: chain — operand_a <= result, count_a=DIGITS, operand_b=0, latch opcode, go to ENTER_B.
  - E: ignored.
- ERROR: error=1 and display_value=0. Only D exits.
- display_value by state:
  - ENTER_A: operand_a.
  - ENTER_B: operand_b if count_b > 0, else operand_a.
  - RESULT: latched result.
- Reset asserted mid-REQUEST: calc_req=0 on the next cycle. A late calc_ack after reset is ignored.
- calc_ack outside REQUEST is ignored.

Decomposition:
- Shared package calc_pkg:
  - keycode constants KEY_ADD=A, KEY_SUB=B, KEY_MUL=C, KEY_CLR=D, KEY_EQ=E.
  - opcode enum.
  - state enum: ENTER_A=0, ENTER_B=1, REQUEST=2, RESULT=3, ERROR=4.
- One sub-module, digit_accumulator: value/count registers, the *10+d update, the DIGITS limit, and clear/load controls. Instantiated twice, for operands A and B.

Test Plan:
- Reset, then keys 1,2,A,3,E -> calc_req=1, operand_a=12, operand_b=3, opcode=00. Then calc_ack with calc_result=15 -> calc_req=0 next cycle, display_value=15, state=RESULT.
- Keys 1,2,3,4,5 -> operand_a=1234; fifth digit ignored. Then D -> operand_a=0, display_value=0.
- Keys A, 7, A, B, 2, E -> leading A ignored, opcode=01 (sub), operand_a=7, operand_b=2. Also keypressed held high 50 cycles on key 9 -> exactly one digit added.
- REQUEST with no ack for ACK_TIMEOUT cycles -> calc_req=0, error=1, display_value=0; key 5 ignored; D -> ENTER_A.
- From RESULT=15: keys C,2,E -> operand_a=15, opcode=10, operand_b=2, calc_req=1. Then calc_ack with calc_error=1 -> state=ERROR.
- Reset asserted while calc_req=1 -> calc_req=0 next cycle, state=ENTER_A; calc_ack pulse one cycle later has no effect.
